l2_cache_update_queue: RTL and testbench

L2_CACHE_UPDATE_QUEUE -- requirements
Module: l2_cache_update_queue

---
 rtl/l2_cache_update_queue.sv | 178 +++++++++++++++++
 tb/tb_l2_cache_update_queue.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_update_queue.sv
// L2 cache update stage: merges store data into the cached or filled line,
// drives the cache write port and queues responses in a circular FIFO.
module l2_cache_update_queue #(
  parameter int LINE_BYTES = 64,
  parameter int IDX_WIDTH  = 8,
  parameter int CORE_WIDTH = 2,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 26,
  parameter int RSP_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    l2r_request_valid,
  input  logic [2:0]              l2r_packet_type,
  input  logic [CORE_WIDTH-1:0]   l2r_core,
  input  logic [ID_WIDTH-1:0]     l2r_id,
  input  logic [ADDR_WIDTH-1:0]   l2r_address,
  input  logic                    l2r_cache_type,
  input  logic [LINE_BYTES-1:0]   l2r_store_mask,
  input  logic [8*LINE_BYTES-1:0] l2r_store_data,
  input  logic [8*LINE_BYTES-1:0] l2r_data,
  input  logic [8*LINE_BYTES-1:0] l2r_fill_data,
  input  logic                    l2r_cache_hit,
  input  logic                    l2r_is_l2_fill,
  input  logic                    l2r_is_restarted_flush,
  input  logic                    l2r_needs_writeback,
  input  logic                    l2r_sync_success,
  input  logic [IDX_WIDTH-1:0]    l2r_hit_idx,
  output logic                    l2u_write_en,
  output logic [IDX_WIDTH-1:0]    l2u_write_addr,
  output logic [8*LINE_BYTES-1:0] l2u_write_data,
  output logic                    l2u_stall,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_status,
  output logic [2:0]              rsp_type,
  output logic [CORE_WIDTH-1:0]   rsp_core,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic [ADDR_WIDTH-1:0]   rsp_address,
  output logic                    rsp_cache_type,
  output logic [8*LINE_BYTES-1:0] rsp_data,
  output logic                    overflow_err
);

  localparam int DATA_W = 8 * LINE_BYTES;
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL  = (PTR_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W:0] STALL_LEVEL = (PTR_W + 1)'(RSP_DEPTH - 2);

  localparam logic [2:0] PT_LOAD        = 3'd0;
  localparam logic [2:0] PT_STORE       = 3'd1;
  localparam logic [2:0] PT_FLUSH       = 3'd2;
  localparam logic [2:0] PT_DINVALIDATE = 3'd3;
  localparam logic [2:0] PT_IINVALIDATE = 3'd4;
  localparam logic [2:0] PT_LOAD_SYNC   = 3'd5;
  localparam logic [2:0] PT_STORE_SYNC  = 3'd6;
  localparam logic [2:0] PT_LOCK        = 3'd7;

  localparam logic [2:0] RSP_LOAD_ACK  = 3'd0;
  localparam logic [2:0] RSP_STORE_ACK = 3'd1;
  localparam logic [2:0] RSP_FLUSH_ACK = 3'd2;
  localparam logic [2:0] RSP_IINV_ACK  = 3'd3;
  localparam logic [2:0] RSP_DINV_ACK  = 3'd4;

  logic              is_store;
  logic              update;
  logic              completed_flush;
  logic              push;
  logic              pop;
  logic              full;
  logic              do_write;
  logic              push_status;
  logic [2:0]        push_type;
  logic [DATA_W-1:0] original;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_next;

  logic [2:0]            mem_type   [RSP_DEPTH];
  logic                  mem_status [RSP_DEPTH];
  logic [CORE_WIDTH-1:0] mem_core   [RSP_DEPTH];
  logic [ID_WIDTH-1:0]   mem_id     [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr   [RSP_DEPTH];
  logic                  mem_ctype  [RSP_DEPTH];
  logic [DATA_W-1:0]     mem_data   [RSP_DEPTH];

  assign is_store = (l2r_packet_type == PT_STORE) || (l2r_packet_type == PT_STORE_SYNC);
  assign update   = (l2r_packet_type == PT_STORE)
                  || ((l2r_packet_type == PT_STORE_SYNC) && l2r_sync_success);
  assign original = l2r_is_l2_fill ? l2r_fill_data : l2r_data;

  always_comb begin
    l2u_write_data = original;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (update && l2r_store_mask[b]) begin
        l2u_write_data[8*b +: 8] = l2r_store_data[8*b +: 8];
      end
    end
  end

  assign l2u_write_en   = l2r_request_valid && (l2r_is_l2_fill || (l2r_cache_hit && is_store));
  assign l2u_write_addr = l2r_hit_idx;

  // A flush only completes once no dirty writeback is outstanding for the line.
  assign completed_flush = (l2r_packet_type == PT_FLUSH)
                         && (l2r_is_restarted_flush || !l2r_cache_hit || !l2r_needs_writeback);
  assign push = l2r_request_valid
              && ((l2r_cache_hit && (l2r_packet_type != PT_FLUSH)) || l2r_is_l2_fill
                  || completed_flush || (l2r_packet_type == PT_DINVALIDATE)
                  || (l2r_packet_type == PT_IINVALIDATE));

  always_comb begin
    push_type = RSP_LOAD_ACK;
    case (l2r_packet_type)
      PT_LOAD, PT_LOAD_SYNC, PT_LOCK: push_type = RSP_LOAD_ACK;
      PT_STORE, PT_STORE_SYNC:        push_type = RSP_STORE_ACK;
      PT_FLUSH:                       push_type = RSP_FLUSH_ACK;
      PT_IINVALIDATE:                 push_type = RSP_IINV_ACK;
      PT_DINVALIDATE:                 push_type = RSP_DINV_ACK;
      default:                        push_type = RSP_LOAD_ACK;
    endcase
  end

  assign push_status = (l2r_packet_type == PT_STORE_SYNC) ? l2r_sync_success : 1'b1;

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign full      = (count == FULL_LEVEL);
  // When full, a push still fits if the head leaves in the same cycle.
  assign do_write  = push && (!full || pop);

  always_comb begin
    count_next = count;
    if (do_write && !pop) begin
      count_next = count + 1'b1;
    end else if (!do_write && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      l2u_stall    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      l2u_stall <= (count_next >= STALL_LEVEL);
      if (push && full && !pop) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_type[wr_ptr]   <= push_type;
      mem_status[wr_ptr] <= push_status;
      mem_core[wr_ptr]   <= l2r_core;
      mem_id[wr_ptr]     <= l2r_id;
      mem_addr[wr_ptr]   <= l2r_address;
      mem_ctype[wr_ptr]  <= l2r_cache_type;
      mem_data[wr_ptr]   <= l2u_write_data;
    end
  end

  assign rsp_type       = mem_type[rd_ptr];
  assign rsp_status     = mem_status[rd_ptr];
  assign rsp_core       = mem_core[rd_ptr];
  assign rsp_id         = mem_id[rd_ptr];
  assign rsp_address    = mem_addr[rd_ptr];
  assign rsp_cache_type = mem_ctype[rd_ptr];
  assign rsp_data       = mem_data[rd_ptr];

endmodule

// File: tb/tb_l2_cache_update_queue.sv
// Self-checking bench for l2_cache_update_queue: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_l2_cache_update_queue;

  localparam int LINE_BYTES = 64;
  localparam int IDX_WIDTH  = 8;
  localparam int CORE_WIDTH = 2;
  localparam int ID_WIDTH   = 2;
  localparam int ADDR_WIDTH = 26;
  localparam int RSP_DEPTH  = 8;
  localparam int DW = 8 * LINE_BYTES;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic l2r_request_valid;
  logic [2:0] l2r_packet_type;
  logic [CORE_WIDTH-1:0] l2r_core;
  logic [ID_WIDTH-1:0] l2r_id;
  logic [ADDR_WIDTH-1:0] l2r_address;
  logic l2r_cache_type;
  logic [LINE_BYTES-1:0] l2r_store_mask;
  logic [DW-1:0] l2r_store_data, l2r_data, l2r_fill_data;
  logic l2r_cache_hit, l2r_is_l2_fill, l2r_is_restarted_flush, l2r_needs_writeback, l2r_sync_success;
  logic [IDX_WIDTH-1:0] l2r_hit_idx;
  logic l2u_write_en;
  logic [IDX_WIDTH-1:0] l2u_write_addr;
  logic [DW-1:0] l2u_write_data;
  logic l2u_stall, rsp_valid, rsp_ready, rsp_status, rsp_cache_type, overflow_err;
  logic [2:0] rsp_type;
  logic [CORE_WIDTH-1:0] rsp_core;
  logic [ID_WIDTH-1:0] rsp_id;
  logic [ADDR_WIDTH-1:0] rsp_address;
  logic [DW-1:0] rsp_data;

  l2_cache_update_queue #(
    .LINE_BYTES(LINE_BYTES), .IDX_WIDTH(IDX_WIDTH), .CORE_WIDTH(CORE_WIDTH),
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .l2r_request_valid(l2r_request_valid), .l2r_packet_type(l2r_packet_type),
    .l2r_core(l2r_core), .l2r_id(l2r_id), .l2r_address(l2r_address),
    .l2r_cache_type(l2r_cache_type), .l2r_store_mask(l2r_store_mask),
    .l2r_store_data(l2r_store_data), .l2r_data(l2r_data), .l2r_fill_data(l2r_fill_data),
    .l2r_cache_hit(l2r_cache_hit), .l2r_is_l2_fill(l2r_is_l2_fill),
    .l2r_is_restarted_flush(l2r_is_restarted_flush), .l2r_needs_writeback(l2r_needs_writeback),
    .l2r_sync_success(l2r_sync_success), .l2r_hit_idx(l2r_hit_idx),
    .l2u_write_en(l2u_write_en), .l2u_write_addr(l2u_write_addr), .l2u_write_data(l2u_write_data),
    .l2u_stall(l2u_stall), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_type(rsp_type), .rsp_core(rsp_core), .rsp_id(rsp_id),
    .rsp_address(rsp_address), .rsp_cache_type(rsp_cache_type), .rsp_data(rsp_data),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid; logic [2:0] ptype; logic [CORE_WIDTH-1:0] core; logic [ID_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr; logic ctype; logic [LINE_BYTES-1:0] mask;
    logic [DW-1:0] store_data, data, fill_data;
    logic hit, fill, restarted, wb, sync; logic [IDX_WIDTH-1:0] idx;
  } req_t;

  typedef struct {
    logic [2:0] rtype; logic status; logic [CORE_WIDTH-1:0] core; logic [ID_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr; logic ctype; logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  bit   model_ovf;
  bit   model_stall;
  req_t cur;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic req_t idle_req();
    req_t r;
    r.valid = 0; r.ptype = 0; r.core = 0; r.id = 0; r.addr = 0; r.ctype = 0; r.mask = 0;
    r.store_data = 0; r.data = 0; r.fill_data = 0;
    r.hit = 0; r.fill = 0; r.restarted = 0; r.wb = 0; r.sync = 0; r.idx = 0;
    return r;
  endfunction

  function automatic req_t load_req(int n);
    req_t r = idle_req();
    r.valid = 1; r.ptype = 3'd0; r.hit = 1; r.addr = ADDR_WIDTH'(n * 17 + 3);
    r.id = ID_WIDTH'(n); r.core = CORE_WIDTH'(n >> 2); r.data = rand_line(); r.idx = IDX_WIDTH'(n);
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.valid = ($urandom_range(0, 9) < 6); r.ptype = 3'($urandom_range(0, 7));
    r.core = CORE_WIDTH'($urandom()); r.id = ID_WIDTH'($urandom());
    r.addr = ADDR_WIDTH'($urandom()); r.ctype = 1'($urandom());
    r.mask = {$urandom(), $urandom()};
    r.store_data = rand_line(); r.data = rand_line(); r.fill_data = rand_line();
    r.hit = 1'($urandom()); r.fill = ($urandom_range(0, 3) == 0);
    r.restarted = 1'($urandom()); r.wb = 1'($urandom()); r.sync = 1'($urandom());
    r.idx = IDX_WIDTH'($urandom());
    return r;
  endfunction

  // Reference model: merged line, write enable, response push and response contents.
  function automatic logic [DW-1:0] exp_wdata(req_t r);
    logic [DW-1:0] line = r.fill ? r.fill_data : r.data;
    bit upd = (r.ptype == 3'd1) || (r.ptype == 3'd6 && r.sync);
    for (int b = 0; b < LINE_BYTES; b++)
      if (upd && r.mask[b]) line[8*b +: 8] = r.store_data[8*b +: 8];
    return line;
  endfunction

  function automatic bit exp_wen(req_t r);
    return r.valid && (r.fill || (r.hit && (r.ptype == 3'd1 || r.ptype == 3'd6)));
  endfunction

  function automatic bit exp_push(req_t r);
    bit flush_done = (r.ptype == 3'd2) && (r.restarted || !r.hit || !r.wb);
    return r.valid && ((r.hit && r.ptype != 3'd2) || r.fill || flush_done
                       || r.ptype == 3'd3 || r.ptype == 3'd4);
  endfunction

  function automatic rsp_t exp_rsp(req_t r);
    rsp_t e;
    case (r.ptype)
      3'd1, 3'd6: e.rtype = 3'd1;
      3'd2:       e.rtype = 3'd2;
      3'd4:       e.rtype = 3'd3;
      3'd3:       e.rtype = 3'd4;
      default:    e.rtype = 3'd0;
    endcase
    e.status = (r.ptype == 3'd6) ? r.sync : 1'b1;
    e.core = r.core; e.id = r.id; e.addr = r.addr; e.ctype = r.ctype; e.data = exp_wdata(r);
    return e;
  endfunction

  task automatic drive(req_t r);
    cur = r;
    l2r_request_valid = r.valid; l2r_packet_type = r.ptype; l2r_core = r.core; l2r_id = r.id;
    l2r_address = r.addr; l2r_cache_type = r.ctype; l2r_store_mask = r.mask;
    l2r_store_data = r.store_data; l2r_data = r.data; l2r_fill_data = r.fill_data;
    l2r_cache_hit = r.hit; l2r_is_l2_fill = r.fill; l2r_is_restarted_flush = r.restarted;
    l2r_needs_writeback = r.wb; l2r_sync_success = r.sync; l2r_hit_idx = r.idx;
    #1;
  endtask

  // Advances one clock and applies the same edge to the model.
  task automatic tick();
    bit pop = (exp_q.size() > 0) && rsp_ready;
    bit push = exp_push(cur);
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() == RSP_DEPTH) model_ovf = 1;
      else exp_q.push_back(exp_rsp(cur));
    end
    model_stall = (exp_q.size() >= RSP_DEPTH - 2);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; rsp_ready = 1'b0;
    drive(idle_req());
    exp_q.delete(); model_ovf = 0; model_stall = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0;
    drive(idle_req());
    n_checks++;
    if ({rsp_valid, l2u_stall, overflow_err, l2u_write_en} !== 4'b0000)
      $display("FAIL reset_outputs: got valid/stall/ovf/wen=%b%b%b%b required 0000", rsp_valid, l2u_stall, overflow_err, l2u_write_en);
    else n_pass++;
    reset_dut();
  endtask

  task automatic test_store_hit();
    req_t r = idle_req();
    reset_dut();
    r.valid = 1; r.ptype = 3'd1; r.hit = 1; r.mask = 64'h1; r.store_data[7:0] = 8'hAA; r.idx = 8'h12;
    drive(r);
    n_checks++;
    if (l2u_write_en !== 1'b1 || l2u_write_addr !== 8'h12)
      $display("FAIL store_hit_wen: got en=%b addr=%h required en=1 addr=12", l2u_write_en, l2u_write_addr);
    else n_pass++;
    n_checks++;
    if (l2u_write_data !== DW'(8'hAA))
      $display("FAIL store_hit_wdata: got low=%h required low=00..aa", l2u_write_data[63:0]);
    else n_pass++;
    tick();
    drive(idle_req());
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_type !== 3'd1 || rsp_status !== 1'b1 || rsp_data !== DW'(8'hAA))
      $display("FAIL store_hit_rsp: got v=%b type=%0d status=%b required v=1 type=1 status=1", rsp_valid, rsp_type, rsp_status);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL store_hit_pop: got rsp_valid=%b required 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_store_sync_fail();
    req_t r = idle_req();
    reset_dut();
    r.valid = 1; r.ptype = 3'd6; r.hit = 1; r.sync = 0; r.mask = '1;
    r.store_data = rand_line(); r.data = rand_line(); r.idx = 8'h5;
    drive(r);
    n_checks++;
    if (l2u_write_en !== 1'b1 || l2u_write_data !== r.data)
      $display("FAIL sync_fail_write: got en=%b low=%h required en=1 low=%h", l2u_write_en, l2u_write_data[63:0], r.data[63:0]);
    else n_pass++;
    tick();
    drive(idle_req());
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_type !== 3'd1 || rsp_status !== 1'b0)
      $display("FAIL sync_fail_rsp: got v=%b type=%0d status=%b required v=1 type=1 status=0", rsp_valid, rsp_type, rsp_status);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    req_t r = idle_req();
    reset_dut();
    r.valid = 1; r.ptype = 3'd2; r.hit = 1; r.wb = 1; r.restarted = 0; r.addr = 26'h123;
    drive(r);
    n_checks++;
    if (l2u_write_en !== 1'b0) $display("FAIL flush_wen: got %b required 0", l2u_write_en);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL flush_dirty_no_rsp: got rsp_valid=%b required 0", rsp_valid);
    else n_pass++;
    r.restarted = 1;
    drive(r);
    tick();
    drive(idle_req());
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_type !== 3'd2 || rsp_address !== 26'h123)
      $display("FAIL flush_restarted_rsp: got v=%b type=%0d addr=%h required v=1 type=2 addr=123", rsp_valid, rsp_type, rsp_address);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    rsp_t e;
    reset_dut();
    for (int i = 0; i < RSP_DEPTH + 1; i++) begin
      drive(load_req(i));
      tick();
      if (i == RSP_DEPTH - 4 || i == RSP_DEPTH - 3) begin
        n_checks++;
        if (l2u_stall !== model_stall)
          $display("FAIL stall_level_%0d: got %b required %b", i + 1, l2u_stall, model_stall);
        else n_pass++;
      end
      if (i == RSP_DEPTH - 1 || i == RSP_DEPTH) begin
        n_checks++;
        if (overflow_err !== model_ovf)
          $display("FAIL overflow_after_%0d: got %b required %b", i + 1, overflow_err, model_ovf);
        else n_pass++;
      end
    end
    drive(idle_req());
    rsp_ready = 1'b1;
    for (int i = 0; i < RSP_DEPTH; i++) begin
      e = exp_q[0];
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_address !== e.addr || rsp_data !== e.data)
        $display("FAIL overflow_drain_%0d: got v=%b addr=%h required v=1 addr=%h", i, rsp_valid, rsp_address, e.addr);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || overflow_err !== 1'b1)
      $display("FAIL overflow_dropped: got v=%b ovf=%b required v=0 ovf=1", rsp_valid, overflow_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    req_t r = idle_req();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(load_req(i + 20));
      tick();
    end
    reset = 1'b1;
    #1;
    exp_q.delete(); model_ovf = 0; model_stall = 0;
    n_checks++;
    if ({rsp_valid, overflow_err, l2u_stall} !== 3'b000)
      $display("FAIL reset_mid: got valid/ovf/stall=%b%b%b required 000", rsp_valid, overflow_err, l2u_stall);
    else n_pass++;
    #1 reset = 1'b0;
    r.valid = 1; r.ptype = 3'd4; r.addr = 26'h3A5A5A5; r.data = rand_line();
    drive(r);
    tick();
    drive(idle_req());
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_type !== 3'd3 || rsp_address !== 26'h3A5A5A5)
      $display("FAIL post_reset_push: got v=%b type=%0d addr=%h required v=1 type=3 addr=3a5a5a5", rsp_valid, rsp_type, rsp_address);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL post_reset_drain: got rsp_valid=%b required 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    rsp_t e;
    reset_dut();
    for (int i = 0; i < RSP_DEPTH; i++) begin
      drive(load_req(i + 40));
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(load_req(i + 60));
      e = exp_q[0];
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_address !== e.addr || rsp_id !== e.id || rsp_data !== e.data)
        $display("FAIL b2b_order_%0d: got v=%b addr=%h required v=1 addr=%h", i, rsp_valid, rsp_address, e.addr);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (overflow_err !== 1'b0 || l2u_stall !== 1'b1 || exp_q.size() != RSP_DEPTH)
      $display("FAIL b2b_full: got ovf=%b stall=%b required ovf=0 stall=1", overflow_err, l2u_stall);
    else n_pass++;
    drive(idle_req());
    for (int i = 0; i < RSP_DEPTH; i++) begin
      e = exp_q[0];
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_address !== e.addr)
        $display("FAIL b2b_drain_%0d: got v=%b addr=%h required v=1 addr=%h", i, rsp_valid, rsp_address, e.addr);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL b2b_empty: got rsp_valid=%b required 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    rsp_t e;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive(rand_req());
      n_checks++;
      if (l2u_write_en !== exp_wen(cur) || l2u_write_addr !== cur.idx || l2u_write_data !== exp_wdata(cur))
        $display("FAIL rand_write_%0d: got en=%b addr=%h low=%h required en=%b addr=%h low=%h", i, l2u_write_en, l2u_write_addr, l2u_write_data[63:0], exp_wen(cur), cur.idx, exp_wdata(cur)[63:0]);
      else n_pass++;
      n_checks++;
      if (rsp_valid !== (exp_q.size() != 0) || l2u_stall !== model_stall || overflow_err !== model_ovf)
        $display("FAIL rand_status_%0d: got v/stall/ovf=%b%b%b required %b%b%b", i, rsp_valid, l2u_stall, overflow_err, exp_q.size() != 0, model_stall, model_ovf);
      else n_pass++;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        n_checks++;
        if ({rsp_type, rsp_status, rsp_core, rsp_id, rsp_address, rsp_cache_type} !== {e.rtype, e.status, e.core, e.id, e.addr, e.ctype} || rsp_data !== e.data)
          $display("FAIL rand_head_%0d: got type=%0d st=%b addr=%h required type=%0d st=%b addr=%h", i, rsp_type, rsp_status, rsp_address, e.rtype, e.status, e.addr);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    rsp_ready = 1'b0;
    drive(idle_req());
    test_reset();
    test_store_hit();
    test_store_sync_fail();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
